// File: rtl/button_operand_in.sv
// Operand entry stage for the full adder: three active-low push buttons are
// synchronised, debounced, and each confirmed press toggles a held operand bit.
module button_operand_in #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_n,
  output logic       a_n,
  output logic       b_n,
  output logic       cin_n,
  output logic [2:0] press
);

  typedef enum logic [1:0] {
    UP      = 2'd0,
    WAIT_DN = 2'd1,
    DN      = 2'd2,
    WAIT_UP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] op_bits;
  logic [2:0] pulse_bits;

  // Sync flops reset to released so reset never looks like a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             op_q;
    logic             op_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             s;
    logic             at_max;

    assign s      = sync2[i];
    assign at_max = (cnt_q == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= UP;
        cnt_q   <= '0;
        op_q    <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        op_q    <= op_d;
        pulse_q <= pulse_d;
      end
    end

    // Counter is compared before incrementing, so it saturates at CNT_MAX
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        UP: begin
          if (!s) begin
            state_d = WAIT_DN;
            cnt_d   = '0;
          end
        end
        WAIT_DN: begin
          if (s) begin
            state_d = UP;
            cnt_d   = '0;
          end else if (at_max) begin
            state_d = DN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DN: begin
          if (s) begin
            state_d = WAIT_UP;
            cnt_d   = '0;
          end
        end
        WAIT_UP: begin
          if (!s) begin
            state_d = DN;
            cnt_d   = '0;
          end else if (at_max) begin
            state_d = UP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = UP;
          cnt_d   = '0;
        end
      endcase
    end

    // Only a qualified press toggles; release qualification is silent
    always_comb begin
      pulse_d = 1'b0;
      op_d    = op_q;
      if (state_q == WAIT_DN && !s && at_max) begin
        pulse_d = 1'b1;
        op_d    = ~op_q;
      end
    end

    assign op_bits[i]    = op_q;
    assign pulse_bits[i] = pulse_q;
  end

  assign a_n   = ~op_bits[0];
  assign b_n   = ~op_bits[1];
  assign cin_n = ~op_bits[2];
  assign press = pulse_bits;

endmodule
